// File: rtl/ram_seq_player.sv
// Sequence-RAM controller for the memory game: appends values at a write pointer and
// plays the stored sequence back from address 0 to a latched limit on the LEDs.
module ram_seq_player #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4,
  parameter int SHOW_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              iniciar,
  input  logic              anexar,
  input  logic [DATA_W-1:0] dado_in,
  input  logic [ADDR_W-1:0] limite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] leds,
  output logic              leds_valid,
  output logic              ocupado,
  output logic              pronto,
  output logic [ADDR_W-1:0] prox_end,
  output logic [2:0]        dbg_state_o
);

  // Handshake: iniciar/anexar are level requests taken only when ocupado is low
  // (ready = !ocupado); anything presented while busy is dropped, never queued.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_FETCH = 3'd2,
    S_LOAD  = 3'd3,
    S_SHOW  = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam int MAX_C = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   lim_q;
  logic [ADDR_W-1:0]   prox_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   leds_q;
  logic                we_q;
  logic                valid_q;
  logic                busy_q;
  logic                pronto_q;
  logic [CNT_W-1:0]    cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      lim_q    <= '0;
      prox_q   <= '0;
      data_q   <= '0;
      leds_q   <= '0;
      we_q     <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      pronto_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      pronto_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (iniciar) begin
            lim_q   <= limite;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end else if (anexar) begin
            addr_q  <= prox_q;
            data_q  <= dado_in;
            we_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          we_q    <= 1'b0;
          prox_q  <= prox_q + ADDR_W'(1);
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        // RAM registers addr at the end of FETCH, so q is readable during LOAD.
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          leds_q  <= mem_q;
          valid_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_SHOW;
        end
        S_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            leds_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (addr_q == lim_q) begin
              pronto_q <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              addr_q  <= addr_q + ADDR_W'(1);
              state_q <= S_FETCH;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          we_q    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr    = addr_q;
  assign mem_we      = we_q;
  assign mem_data    = data_q;
  assign leds        = leds_q;
  assign leds_valid  = valid_q;
  assign ocupado     = busy_q;
  assign pronto      = pronto_q;
  assign prox_end    = prox_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_seq_player.sv
// Scoreboard bench for ram_seq_player with a behavioural 16x4 synchronous RAM attached.
module tb_ram_seq_player;
  localparam int SHOW = 4;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       reset_n, iniciar, anexar;
  logic [3:0] dado_in, limite, mem_addr, mem_data, mem_q, leds, prox_end;
  logic       mem_we, leds_valid, ocupado, pronto;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  ram_seq_player #(.ADDR_W(4), .DATA_W(4), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .iniciar(iniciar), .anexar(anexar),
    .dado_in(dado_in), .limite(limite), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_data(mem_data), .mem_q(mem_q), .leds(leds), .leds_valid(leds_valid),
    .ocupado(ocupado), .pronto(pronto), .prox_end(prox_end), .dbg_state_o(dbg_state)
  );

  // Sequence RAM: read-before-write, address registered on the edge.
  logic [3:0] ram_mem [16];
  always @(posedge clk) begin
    if (mem_we) ram_mem[mem_addr] <= mem_data;
    mem_q <= ram_mem[mem_addr];
  end

  logic [3:0] exp_q[$];
  logic [7:0] wr_q[$];
  int         errors = 0;
  int         checks = 0;
  int         exp_prox = 0;
  logic [3:0] ram_model [16];
  int         pronto_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor
  logic prev_valid = 1'b0;
  int   run_len = 0;
  int   blank_len = 0;
  bit   seen = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      run_len    = 0;
      blank_len  = 0;
      seen       = 1'b0;
    end else begin
      if (pronto) pronto_cnt++;
      if (mem_we) begin
        chk("write_expected", int'(wr_q.size() > 0), 1);
        if (wr_q.size() > 0) chk("write_addr_data", {mem_addr, mem_data}, wr_q.pop_front());
      end
      if (!leds_valid) chk("leds_blank_zero", leds, 0);
      if (leds_valid && !prev_valid) begin
        chk("leds_value_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("leds_value", leds, exp_q.pop_front());
        // Blank run between values covers GAP plus the FETCH and LOAD cycles.
        if (seen) chk("blank_len", blank_len, GAP + 2);
        run_len = 1;
      end else if (leds_valid) begin
        run_len++;
      end
      if (!leds_valid && prev_valid) begin
        chk("show_len", run_len, SHOW);
        seen      = 1'b1;
        blank_len = 0;
      end
      if (!leds_valid && seen) blank_len++;
      if (!ocupado) seen = 1'b0;
      prev_valid = leds_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_append(input logic [3:0] v);
    wr_q.push_back({4'(exp_prox), v});
    ram_model[exp_prox] = v;
    anexar  = 1'b1;
    dado_in = v;
    tick();
    anexar = 1'b0;
    chk("we_in_write", mem_we, 1);
    chk("busy_in_write", ocupado, 1);
    tick();
    chk("we_after_write", mem_we, 0);
    exp_prox = (exp_prox + 1) % 16;
    chk("prox_end", prox_end, exp_prox);
  endtask

  task automatic do_play(input int lim, input bit with_anexar, input bit noise);
    int lat;
    int n;
    int p0;
    for (int i = 0; i <= lim; i++) exp_q.push_back(ram_model[i]);
    p0      = pronto_cnt;
    limite  = 4'(lim);
    iniciar = 1'b1;
    anexar  = with_anexar;
    dado_in = 4'd9;
    tick();
    iniciar = 1'b0;
    anexar  = 1'b0;
    if (noise) begin
      iniciar = 1'b1;
      anexar  = 1'b1;
      dado_in = 4'd7;
      limite  = 4'd15;
    end
    lat = 1;
    while (!leds_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("first_latency", lat, 3);
    n = 0;
    while (!pronto && n < 300) begin
      tick();
      n++;
    end
    chk("pronto_seen", pronto, 1);
    iniciar = 1'b0;
    anexar  = 1'b0;
    tick();
    chk("ocupado_after_done", ocupado, 0);
    chk("pronto_one_cycle", pronto, 0);
    chk("pronto_pulses", pronto_cnt - p0, 1);
    chk("leds_q_drained", exp_q.size(), 0);
    chk("prox_unchanged", prox_end, exp_prox);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0;
    iniciar = 1'b1;
    anexar  = 1'b1;
    dado_in = 4'd5;
    limite  = 4'd3;
    tick();
    tick();
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_leds", leds, 0);
    chk("rst_leds_valid", leds_valid, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_prox_end", prox_end, 0);
    chk("rst_state", dbg_state, 0);
    iniciar = 1'b0;
    anexar  = 1'b0;
    reset_n = 1'b1;
    tick();

    do_append(4'd2);
    do_append(4'd1);
    do_append(4'd4);
    do_play(2, 1'b0, 1'b0);
    do_play(0, 1'b0, 1'b0);
    do_play(1, 1'b1, 1'b0);
    do_play(0, 1'b0, 1'b1);

    // Reset during SHOW of the second value.
    for (int i = 0; i <= 2; i++) exp_q.push_back(ram_model[i]);
    limite  = 4'd2;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    n = 0;
    while (!leds_valid && n < 50) begin tick(); n++; end
    while (leds_valid && n < 50) begin tick(); n++; end
    while (!leds_valid && n < 50) begin tick(); n++; end
    chk("second_value_reached", leds_valid, 1);
    tick();
    reset_n = 1'b0;
    tick();
    chk("midrst_leds", leds, 0);
    chk("midrst_leds_valid", leds_valid, 0);
    chk("midrst_ocupado", ocupado, 0);
    chk("midrst_prox_end", prox_end, 0);
    chk("midrst_state", dbg_state, 0);
    exp_q.delete();
    exp_prox = 0;
    reset_n  = 1'b1;
    tick();
    do_play(0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) do_append(4'((i * 7 + 3) % 16));
    chk("prox_wrapped", prox_end, 0);
    do_append(4'd11);
    do_play(3, 1'b0, 1'b0);

    tick();
    chk("wr_q_drained", wr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
